// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot ring priority pointer and grant hold timeout.
// Grants exactly one requester at a time; every output is a flop.
module ring_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [N-1:0]                           req,
  input  logic [N-1:0]                           done,
  output logic [N-1:0]                           grant,
  output logic                                   grant_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   grant_id,
  output logic [N-1:0]                           ptr,
  output logic                                   timeout
);

  localparam int unsigned ID_W  = (N > 1) ? $clog2(N) : 1;
  // Keep the counter at least one bit wide so MAX_HOLD=0 (unlimited) still elaborates.
  localparam int unsigned CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q;
  logic [N-1:0]      ptr_q;
  logic [N-1:0]      grant_q;
  logic              grant_valid_q;
  logic [ID_W-1:0]   grant_id_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  hold_cnt_q;

  logic [ID_W-1:0]   ptr_idx;
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic [N-1:0]      pick_onehot;
  logic              w_done;
  logic              w_req;
  logic              expired;
  logic              rel;

  function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
    return (v << 1) | (v >> (N - 1));
  endfunction

  // Ring scan starting at the pointer slot, wrapping N-1 -> 0.
  always_comb begin
    int idx;
    ptr_idx     = '0;
    pick_found  = 1'b0;
    pick_id     = '0;
    pick_onehot = '0;
    idx         = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (ptr_q[i]) ptr_idx = ID_W'(i);
    end
    for (int i = 0; i < int'(N); i++) begin
      idx = (int'(ptr_idx) + i) % int'(N);
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (pick_found && (ID_W'(i) == pick_id)) pick_onehot[i] = 1'b1;
    end
  end

  // Only the granted bit of done/req can release the grant.
  always_comb begin
    w_done  = |(done & grant_q);
    w_req   = |(req & grant_q);
    expired = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));
    rel     = w_done || !w_req || expired;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      ptr_q         <= N'(1);
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      timeout_q     <= 1'b0;
      hold_cnt_q    <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_found) begin
            grant_q       <= pick_onehot;
            grant_id_q    <= pick_id;
            grant_valid_q <= 1'b1;
            hold_cnt_q    <= CNT_W'(1);
            state_q       <= StBusy;
          end
        end
        StBusy: begin
          if (rel) begin
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            hold_cnt_q    <= '0;
            ptr_q         <= rotl1(grant_q);
            // Flag only a pure expiry; a coincident done or req drop is a normal release.
            timeout_q     <= expired && w_req && !w_done;
            state_q       <= StIdle;
          end else if (MAX_HOLD != 0) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign ptr         = ptr_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Scoreboard bench for ring_rr_arbiter (N=4, MAX_HOLD=8): stimulus queues expected grants,
// a negedge monitor checks each grant's identity, duration, timeout flag and next pointer.
module tb_ring_rr_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] ptr;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] g;
    int         id;
    int         len;
    logic       to;
    logic [3:0] pa;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   active = 1'b0;
  int   cnt = 0;

  ring_rr_arbiter #(
    .N        (4),
    .MAX_HOLD (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .ptr         (ptr),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void expect_grant(input logic [3:0] g, input int id, input int len,
                                       input logic to, input logic [3:0] pa);
    exp_t e;
    e.g = g; e.id = id; e.len = len; e.to = to; e.pa = pa;
    q.push_back(e);
  endfunction

  // Monitor: grant rise pops an expectation, grant fall closes it out.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active = 1'b0;
      end else if (grant_valid && !active) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got %0h expected none at %0t", grant, $time);
        end else begin
          cur = q.pop_front();
          chk("grant", 32'(grant), 32'(cur.g));
          chk("grant_id", 32'(grant_id), 32'(cur.id));
          active = 1'b1;
          cnt    = 1;
        end
      end else if (grant_valid && active) begin
        cnt++;
        chk("grant_hold", 32'(grant), 32'(cur.g));
      end else if (!grant_valid && active) begin
        active = 1'b0;
        chk("grant_len", 32'(cnt), 32'(cur.len));
        chk("timeout_flag", 32'(timeout), 32'(cur.to));
        chk("ptr_after", 32'(ptr), 32'(cur.pa));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    int n = 0;
    while (!grant_valid && n < 20) begin
      step();
      n++;
    end
    chk("grant_wait", 32'(grant_valid), 32'd1);
  endtask

  // Hold the grant for len cycles, then release by done (use_done) or by dropping req.
  task automatic serve(input int len, input bit use_done);
    wait_grant();
    repeat (len - 1) step();
    if (use_done) done = grant;
    else req = 4'b0000;
    step();
    done = 4'b0000;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    req     = 4'b1111;
    done    = 4'b0000;

    // 1: reset state, then first grant one edge after release
    repeat (2) step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ptr", 32'(ptr), 32'h1);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_valid", 32'(grant_valid), 32'h0);
    chk("rst_id", 32'(grant_id), 32'h0);
    expect_grant(4'b0001, 0, 2, 1'b0, 4'b0010);
    expect_grant(4'b0010, 1, 2, 1'b0, 4'b0100);
    expect_grant(4'b0100, 2, 2, 1'b0, 4'b1000);
    expect_grant(4'b1000, 3, 2, 1'b0, 4'b0001);
    expect_grant(4'b0001, 0, 2, 1'b0, 4'b0010);
    reset_n = 1'b1;
    step();
    chk("first_grant", 32'(grant), 32'h1);

    // 2: rotation with all requesting
    repeat (5) serve(2, 1'b1);
    req = 4'b0000;
    step();
    chk("idle_after_rot", 32'(grant_valid), 32'h0);

    // 3: move ptr to slot 2, then req 0011 wraps to requester 0
    expect_grant(4'b0010, 1, 2, 1'b0, 4'b0100);
    expect_grant(4'b0001, 0, 3, 1'b0, 4'b0010);
    req = 4'b0010;
    serve(2, 1'b1);
    req = 4'b0011;
    serve(3, 1'b0);

    // 4: hold expiry
    expect_grant(4'b0100, 2, 8, 1'b1, 4'b1000);
    req = 4'b0100;
    wait_grant();
    n = 0;
    while (grant_valid && n < 20) begin
      step();
      n++;
    end
    chk("expiry_release", 32'(grant_valid), 32'h0);
    req = 4'b0000;
    step();
    chk("timeout_pulse_1cyc", 32'(timeout), 32'h0);

    // 5: done on the expiry edge, plus a stray done on a non-granted bit
    expect_grant(4'b1000, 3, 8, 1'b0, 4'b0001);
    req = 4'b1000;
    wait_grant();
    step();
    done = 4'b0010;
    step();
    done = 4'b0000;
    chk("stray_done", 32'(grant), 32'h8);
    repeat (5) step();
    done = 4'b1000;
    step();
    done = 4'b0000;
    req  = 4'b0000;
    step();

    // 6: async reset in the middle of a grant
    expect_grant(4'b1000, 3, 0, 1'b0, 4'b0000);
    req = 4'b1000;
    wait_grant();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_valid", 32'(grant_valid), 32'h0);
    chk("async_id", 32'(grant_id), 32'h0);
    chk("async_ptr", 32'(ptr), 32'h1);
    chk("async_timeout", 32'(timeout), 32'h0);
    step();
    expect_grant(4'b0010, 1, 2, 1'b0, 4'b0100);
    req     = 4'b1010;
    reset_n = 1'b1;
    step();
    chk("restart_grant", 32'(grant), 32'h2);
    serve(2, 1'b1);
    req = 4'b0000;

    repeat (3) step();
    chk("queue_drained", 32'(q.size()), 32'h0);
    chk("monitor_idle", 32'(active), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
